// File: rtl/rom_char_reader.sv
// -----------------------------------------------------------------------------
// rom_char_reader
//
// Character source for the HTML parsing front end. A page image sits in a ROM
// and is streamed out one character per request from the parser FSM. The
// stream ends at a NUL entry or at the end of the ROM. In loop mode it wraps
// back to START_ADDR and keeps going instead.
//
// Ports
//   clock         in   1          system clock, rising edge
//   resetn        in   1          asynchronous, active-low reset
//   state_enable  in   1          request level; one character per low->high period
//   rewind        in   1          synchronous restart of the stream
//   char          out  CHAR_W     current character, held until the next one
//   char_valid    out  1          one-cycle pulse when char is updated
//   has_finished  out  1          stream exhausted (LOOP=0 only), sticky
//   char_count    out  ADDR_W+1   characters emitted in the current pass
//
// ROM contents come from INIT_IMAGE (entry i at bits [i*CHAR_W +: CHAR_W]).
// -----------------------------------------------------------------------------
module rom_char_reader #(
    parameter int                      CHAR_W     = 8,
    parameter int                      DEPTH      = 64,
    parameter int                      ADDR_W     = 6,
    parameter string                   INIT_FILE  = "page.hex",
    parameter int                      START_ADDR = 1,
    parameter bit                      LOOP       = 1'b0,
    parameter logic [DEPTH*CHAR_W-1:0] INIT_IMAGE = '0
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              state_enable,
    input  logic              rewind,
    output logic [CHAR_W-1:0] char,
    output logic              char_valid,
    output logic              has_finished,
    output logic [ADDR_W:0]   char_count
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        READ,
        WAIT_LOW,
        DONE
    } state_t;

    localparam logic [ADDR_W:0] START    = (ADDR_W+1)'(START_ADDR);
    localparam logic [ADDR_W:0] END_ADDR = (ADDR_W+1)'(DEPTH);

    state_t            state;
    logic [ADDR_W:0]   addr;
    logic [CHAR_W-1:0] q;
    logic              at_end;

    logic [CHAR_W-1:0] mem [DEPTH];

    // ROM image taken from the INIT_IMAGE parameter.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = INIT_IMAGE[i*CHAR_W +: CHAR_W];
        end
    end

    // Synchronous ROM read. addr has one spare bit so that addr==DEPTH can
    // mark the end of the image; only the low bits index the array.
    always_ff @(posedge clock) begin
        q <= mem[addr[ADDR_W-1:0]];
    end

    // '>=' also covers a START_ADDR placed beyond the image.
    assign at_end = (addr >= END_ADDR) || (q == '0);

    // Request FSM. Rewind has priority over everything else and cancels
    // any read that is still in FETCH/READ.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            addr         <= START;
            char         <= '0;
            char_valid   <= 1'b0;
            has_finished <= 1'b0;
            char_count   <= '0;
        end else if (rewind) begin
            addr         <= START;
            has_finished <= 1'b0;
            char_count   <= '0;
            char_valid   <= 1'b0;
            // A request level still high during rewind must not count as a
            // new request, so wait for it to drop first.
            state        <= state_enable ? WAIT_LOW : IDLE;
        end else begin
            char_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (state_enable) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    state <= READ;
                end
                READ: begin
                    if (!at_end) begin
                        char       <= q;
                        char_valid <= 1'b1;
                        addr       <= addr + 1'b1;
                        char_count <= char_count + 1'b1;
                        state      <= WAIT_LOW;
                    end else if (LOOP) begin
                        // Wrap and re-fetch so the pending request is still served.
                        addr       <= START;
                        char_count <= '0;
                        state      <= FETCH;
                    end else begin
                        has_finished <= 1'b1;
                        state        <= DONE;
                    end
                end
                WAIT_LOW: begin
                    if (!state_enable) begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
